dsd_decimator: RTL and testbench

//  Delta-sigma demodulator: third-order CIC (sinc^3) decimator turning a 1-bit density stream into signed
//  16-bit PCM samples. Each sample is pushed into a show-ahead FIFO using the wrreq/full write handshake.
//  It is the capture-side counterpart of the 1-bit modulator, which reads PCM from a FIFO with rdreq/empty.

---
 rtl/dsd_decimator.sv | 173 +++++++++++++++++
 tb/tb_dsd_decimator.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dsd_decimator.sv
// Third-order CIC (sinc^3) decimator: 1-bit density stream in, signed PCM samples out via wrreq/full.
// Optional build macro DSD_OVF_STATUS_EN adds a sticky overflow flag and a saturating drop counter.
module dsd_decimator #(
    parameter int unsigned R_LOG2 = 7,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned FILL_N = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             insignal,
    output logic [OUT_W-1:0] data_out,
    output logic             wrreq,
    input  logic             full,
    output logic             ovf,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned ACC_W  = 3 * R_LOG2 + 1;
    localparam int unsigned SW     = ACC_W + 1;
    localparam int unsigned SHIFT  = 3 * R_LOG2 - OUT_W;
    localparam int unsigned FILL_W = (FILL_N < 2) ? 1 : $clog2(FILL_N + 1);

    localparam logic signed [SW-1:0] MID   = SW'(2 ** (3 * R_LOG2 - 1));
    localparam logic signed [SW-1:0] S_MAX = SW'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [SW-1:0] S_MIN = -S_MAX - SW'(1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync_q;
    logic [ACC_W-1:0]    i1_q, i2_q, i3_q;
    logic [ACC_W-1:0]    d1_q, d2_q, d3_q;
    logic [R_LOG2-1:0]   dec_cnt_q;
    logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [OUT_W-1:0]    data_out_q, data_out_d;
    logic                wr_pend_q, wr_pend_d;

    logic                strobe_c;
    logic [ACC_W-1:0]    c1_c, c2_c, c3_c;
    logic signed [SW-1:0] s_wide_c, s_shift_c, s_sat_c;
    logic [OUT_W-1:0]    sample_c;

    // Input synchronizer, integrators and decimation counter run every clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            i1_q      <= '0;
            i2_q      <= '0;
            i3_q      <= '0;
            dec_cnt_q <= '0;
        end else begin
            sync_q    <= {sync_q[0], insignal};
            i1_q      <= i1_q + ACC_W'(sync_q[1]);
            i2_q      <= i2_q + i1_q;
            i3_q      <= i3_q + i2_q;
            dec_cnt_q <= dec_cnt_q + R_LOG2'(1);
        end
    end

    assign strobe_c = (dec_cnt_q == '1);

    // Comb section: wrap-around arithmetic is exact because the true c3 fits in ACC_W bits.
    always_comb begin
        c1_c = i3_q - d1_q;
        c2_c = c1_c - d2_q;
        c3_c = c2_c - d3_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d1_q <= '0;
            d2_q <= '0;
            d3_q <= '0;
        end else if (strobe_c) begin
            d1_q <= i3_q;
            d2_q <= c1_c;
            d3_q <= c2_c;
        end
    end

    // Recentre around mid-scale, drop fractional bits, clip the single +full-scale code.
    always_comb begin
        s_wide_c  = $signed({1'b0, c3_c}) - MID;
        s_shift_c = s_wide_c >>> SHIFT;
        if (s_shift_c > S_MAX) begin
            s_sat_c = S_MAX;
        end else if (s_shift_c < S_MIN) begin
            s_sat_c = S_MIN;
        end else begin
            s_sat_c = s_shift_c;
        end
        sample_c = OUT_W'(s_sat_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FILL;
            fill_cnt_q <= '0;
            data_out_q <= '0;
            wr_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            data_out_q <= data_out_d;
            wr_pend_q  <= wr_pend_d;
        end
    end

    // FILL discards the settling outputs; RUN publishes one sample per strobe.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        data_out_d = data_out_q;
        wr_pend_d  = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                if (strobe_c) begin
                    fill_cnt_d = fill_cnt_q + FILL_W'(1);
                    if (fill_cnt_q == FILL_W'(FILL_N - 1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (strobe_c) begin
                    data_out_d = sample_c;
                    wr_pend_d  = 1'b1;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    assign data_out = data_out_q;
    assign wrreq    = wr_pend_q & ~full;

`ifdef DSD_OVF_STATUS_EN
    logic       ovf_q, ovf_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // A pending sample that meets full=1 is lost; record it.
    always_comb begin
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (wr_pend_q && full) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;
`else
    assign ovf      = 1'b0;
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_dsd_decimator.sv
// Scoreboard bench for dsd_decimator: expected samples queued as stimulus is driven, checked on wrreq.
module tb_dsd_decimator;

    localparam int R     = 128;
    localparam int FIRST = 4 * R;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        insignal = 1'b0;
    logic        full = 1'b0;
    logic [15:0] data_out;
    logic        wrreq;
    logic        ovf;
    logic [7:0]  drop_cnt;

    int   cyc;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   active = 1'b0;
    exp_t sb_q[$];

    dsd_decimator dut (
        .clk      (clk),
        .reset    (reset),
        .insignal (insignal),
        .data_out (data_out),
        .wrreq    (wrreq),
        .full     (full),
        .ovf      (ovf),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
    endtask

    // Output monitor: slot timing plus scoreboard pop on each write.
    always @(negedge clk) begin
        if (active && !reset) begin
            if ((cyc % R) == 0 && cyc >= R)
                check("wrreq_slot", 32'(wrreq), 32'((cyc >= FIRST) && !full));
            else if (wrreq)
                check("wrreq_offslot", 32'(wrreq), 32'd0);
            if (wrreq) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'(wrreq), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("wr_cycle", 32'(cyc), 32'(e.cyc));
                    check("data_out", 32'(data_out), 32'(e.data));
                end
            end
        end
    end

    // mode 0: all zeros, 1: all ones, 2: toggling starting with 1
    task automatic run_pattern(input int mode, input int ncyc, input int blk_slot, input bit all_full);
        logic [15:0] exp_d;
        reset = 1'b1;
        full  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_wrreq", 32'(wrreq), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        active = 1'b1;
        exp_d = (mode == 0) ? 16'h8000 : (mode == 1) ? 16'h7FFF : 16'h0000;
        for (int c = 0; c < ncyc; c++) begin
            case (mode)
                0:       insignal = 1'b0;
                1:       insignal = 1'b1;
                default: insignal = ~c[0];
            endcase
            if ((c % R) == 0 && c >= FIRST) begin
                full = all_full || (c == blk_slot);
                if (!full) sb_q.push_back('{c, exp_d});
            end else begin
                full = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
        end
        check("sb_drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic exp_ovf;
        logic [7:0] exp_drop1, exp_drop_sat;
`ifdef DSD_OVF_STATUS_EN
        exp_ovf      = 1'b1;
        exp_drop1    = 8'd1;
        exp_drop_sat = 8'd255;
`else
        exp_ovf      = 1'b0;
        exp_drop1    = 8'd0;
        exp_drop_sat = 8'd0;
`endif
        repeat (3) @(posedge clk);
        #1;

        run_pattern(0, 1200, -1, 1'b0);
        run_pattern(1, 1000, -1, 1'b0);
        run_pattern(2, 1000, -1, 1'b0);

        run_pattern(2, 1100, 768, 1'b0);
        check("ovf_one_drop", 32'(ovf), 32'(exp_ovf));
        check("drop_cnt_one", 32'(drop_cnt), 32'(exp_drop1));

        // stop in RUN with dec_cnt = 60; the next run asserts reset in that cycle
        run_pattern(0, FIRST + 60, -1, 1'b0);
        run_pattern(1, 700, -1, 1'b0);

        run_pattern(0, FIRST + 300 * R, -1, 1'b1);
        check("ovf_many_drops", 32'(ovf), 32'(exp_ovf));
        check("drop_cnt_sat", 32'(drop_cnt), 32'(exp_drop_sat));

        run_pattern(0, 10, -1, 1'b0);
        active = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
